conv_out_writer: RTL and testbench
==================================

# conv_out_writer

Consumer end of the convolution result stream. Takes each 24-bit result with its 13-bit output address and valid flag from the convolution controller, quantizes it to 8 bits, and writes it into the output RAM. After a full frame has been collected, it reads the RAM back in address order and streams the bytes out over a valid/ready byte interface to the board-test transmitter.

## Interface
Parameters:
- img_size, 8'h1C: output feature-map side length.
- filter_size, 4'b0110: number of filters.
- shift, 5'd8: arithmetic right shift applied before saturation.
- TOTAL (localparam): img_size*img_size*filter_size (4704 by default); must be ≤ 8192.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arms collection; honoured only in IDLE.
- in_valid  in  1  result valid (controller's data_out_flag).
- in_data  in  24  result, signed two's complement.
- in_addr  in  13  result address.
- in_done  in  1  controller frame-done.
- ram_addr  out  13  output RAM address (shared by write and read).
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data, valid 1 cycle after ram_addr.
- tx_valid  out  1  byte available.
- tx_data  out  8  byte.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when readout completes.
- seq_err  out  1  sticky error flag; cleared by rst or an accepted start.

## Operation
- States: IDLE, COLLECT, RD_ADDR, RD_WAIT, SEND, FINISH.
- IDLE: all outputs are held low. start → COLLECT, wr_cnt=0, seq_err=0. in_valid is ignored.
- COLLECT: each in_valid produces one registered RAM write, with ram_addr=in_addr and ram_wdata=quant(in_data). wr_cnt then increments.
  - in_addr≠wr_cnt → seq_err=1. The write still uses in_addr.
  - in_valid with wr_cnt==TOTAL → no write, seq_err=1.
  - wr_cnt reaches TOTAL → RD_ADDR, rd_cnt=0.
  - in_done while wr_cnt<TOTAL → seq_err=1 and move to RD_ADDR anyway. Unwritten locations are read as whatever the RAM holds.
- RD_ADDR: drive ram_addr=rd_cnt with ram_we=0 → RD_WAIT.
- RD_WAIT: capture ram_rdata into tx_data → SEND.
- SEND: tx_valid=1. tx_data stays stable until tx_valid&tx_ready.
  - On a handshake with rd_cnt==TOTAL-1 → FINISH.
  - On any other handshake → rd_cnt+1, then RD_ADDR.
- FINISH: done=1 for one cycle → IDLE.
- quant(x): y = x>>>shift, computed at 24-bit signed width, then saturated to 8 bits.
  - Without the macro: clamp to [-128,127].
  - With the macro: see Configuration.
- start outside IDLE is ignored.

## Timing
- Reset values: ram_addr=0, ram_wdata=0, ram_we=0, tx_valid=0, tx_data=0, busy=0, done=0, seq_err=0, state=IDLE.
- Write latency: in_valid in cycle n → ram_we=1 in cycle n+1. Back-to-back in_valid gives back-to-back writes.
- The last accepted write (wr_cnt becomes TOTAL in cycle n+1) → RD_ADDR in cycle n+2. The RAM is never read and written in the same cycle.
- Read: minimum 3 cycles per byte (RD_ADDR, RD_WAIT, SEND with tx_ready=1). Frame readout takes at least 3*TOTAL cycles, plus 1 cycle for FINISH.
- tx_valid never drops without a handshake, except on rst.
- rst mid-operation: in the same edge → IDLE with all reset values. Pending writes and bytes are discarded.

## Configuration
- CONV_OUT_RELU_EN defined: quant clamps y to [0,127], so negatives become 0x00.
- CONV_OUT_RELU_EN undefined: signed saturation to [-128,127]; for example -1 → 0xFF.

## Test plan
All scenarios use img_size=2, filter_size=1 (TOTAL=4) and shift=8.
- Quantization: start, then in_data 0x001234 / 0x7FFF00 / 0xFFFF00 / 0x800000 at addr 0..3, with tx_ready=1.
  - Without the macro, tx bytes are 0x12, 0x7F, 0xFF, 0x80.
  - With CONV_OUT_RELU_EN, tx bytes are 0x12, 0x7F, 0x00, 0x00.
  - done pulses once; seq_err=0.
- Write timing: in_valid at cycle 10 with addr 0 → ram_we=1 and ram_addr=0 at cycle 11. Four consecutive valids → four consecutive writes, then RD_ADDR at cycle 15.
- Backpressure: hold tx_ready=0 for 20 cycles in SEND → tx_valid and tx_data stay stable. Releasing it gives exactly one handshake per byte, 4 bytes in total.
- Sequence errors:
  - Addresses 0,2,… → seq_err=1 from the second write.
  - A fifth in_valid after TOTAL → no write.
  - in_done after 2 writes → seq_err=1 and readout of 4 bytes.
- Reset and start: rst asserted during SEND → next cycle tx_valid=0, busy=0, seq_err=0. start during COLLECT is ignored (wr_cnt is not reset).

Source files
------------

// File: rtl/conv_out_writer.sv
// conv_out_writer: quantizes conv results into output RAM, then streams the frame out bytewise (CONV_OUT_RELU_EN selects ReLU clamp).
module conv_out_writer #(
  parameter logic [7:0] img_size = 8'h1C,
  parameter logic [3:0] filter_size = 4'b0110,
  parameter logic [4:0] shift = 5'd8
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [23:0] in_data,
  input  logic [12:0] in_addr,
  input  logic        in_done,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        seq_err
);
  localparam int TOTAL = int'(img_size) * int'(img_size) * int'(filter_size);
  localparam logic [13:0] TOT = 14'(TOTAL);
  localparam logic [12:0] LAST = 13'(TOTAL - 1);
`ifdef CONV_OUT_RELU_EN
  localparam logic signed [23:0] LO = 24'sd0;
`else
  localparam logic signed [23:0] LO = -24'sd128;
`endif
  typedef enum logic [2:0] {IDLE, COLLECT, RD_ADDR, RD_WAIT, SEND, FINISH} state_t;
  state_t state;
  logic [13:0] wr_cnt;
  logic [12:0] rd_cnt;
  logic signed [23:0] y;
  logic [7:0] q;
  assign y = $signed(in_data) >>> shift;
  assign q = y > 24'sd127 ? 8'h7f : y < LO ? LO[7:0] : y[7:0];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_we <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      done <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          ram_addr <= '0;
          ram_wdata <= '0;
          tx_data <= '0;
          tx_valid <= 1'b0;
          if (start) begin
            state <= COLLECT;
            wr_cnt <= '0;
            seq_err <= 1'b0;
          end
        end
        COLLECT:
          if (wr_cnt == TOT) begin
            if (in_valid) seq_err <= 1'b1;
            state <= RD_ADDR;
            rd_cnt <= '0;
            ram_addr <= '0;
          end else if (in_valid) begin
            ram_we <= 1'b1;
            ram_addr <= in_addr;
            ram_wdata <= q;
            wr_cnt <= wr_cnt + 14'd1;
            if ({1'b0, in_addr} != wr_cnt) seq_err <= 1'b1;
          end else if (in_done) begin
            seq_err <= 1'b1;
            state <= RD_ADDR;
            rd_cnt <= '0;
            ram_addr <= '0;
          end
        // ram_addr is already set on entry so the RAM data lands during RD_WAIT
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          tx_data <= ram_rdata;
          tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND:
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (rd_cnt == LAST) begin
              done <= 1'b1;
              state <= FINISH;
            end else begin
              rd_cnt <= rd_cnt + 13'd1;
              ram_addr <= rd_cnt + 13'd1;
              state <= RD_ADDR;
            end
          end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_out_writer.sv
// tb_conv_out_writer: randomized self-checking bench for conv_out_writer with a 4-entry frame.
module tb_conv_out_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic [12:0] in_addr = '0;
  logic in_done = 1'b0;
  logic [12:0] ram_addr;
  logic [7:0] ram_wdata;
  logic ram_we;
  logic [7:0] ram_rdata;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready = 1'b1;
  logic busy;
  logic done;
  logic seq_err;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mem [0:8191];
  logic [7:0] exp_mem [0:3];

  conv_out_writer #(.img_size(8'd2), .filter_size(4'd1), .shift(5'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .in_done(in_done), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .done(done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (done) done_cnt <= done_cnt + 1;
    if (ram_we) wr_seen <= wr_seen + 1;
  end

  function automatic logic [7:0] quant(input logic [23:0] d);
    int v;
    int y;
    int lo;
    v = $signed(d);
    y = v >>> 8;
`ifdef CONV_OUT_RELU_EN
    lo = 0;
`else
    lo = -128;
`endif
    if (y > 127) y = 127;
    if (y < lo) y = lo;
    return y[7:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic kick;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic put(input int addr, input logic [23:0] d, input bit model);
    in_valid = 1'b1;
    in_addr = 13'(addr);
    in_data = d;
    if (model) exp_mem[addr] = quant(d);
    step;
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input bit rand_ready);
    int base_rx;
    int base_done;
    int n;
    base_rx = rx_q.size();
    base_done = done_cnt;
    n = 0;
    while (done_cnt == base_done && n < 500) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      step;
      n++;
    end
    tx_ready = 1'b1;
    checks++;
    if (done_cnt == base_done) begin
      errors++;
      $display("FAIL %s done_timeout: got no done, required done within 500 cycles", name);
    end
    checks++;
    if (rx_q.size() - base_rx != 4) begin
      errors++;
      $display("FAIL %s byte_count: got %0d, required 4", name, rx_q.size() - base_rx);
    end
    for (int i = 0; i < 4; i++) begin
      if (base_rx + i < rx_q.size()) begin
        checks++;
        if (rx_q[base_rx + i] !== exp_mem[i]) begin
          errors++;
          $display("FAIL %s byte%0d: got %h, required %h", name, i, rx_q[base_rx + i], exp_mem[i]);
        end
      end
    end
    step;
    checks++;
    if (busy !== 1'b0 || done_cnt - base_done != 1) begin
      errors++;
      $display("FAIL %s end_state: got busy=%b done_pulses=%0d, required busy=0 done_pulses=1", name, busy, done_cnt - base_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    checks++;
    if ({ram_addr, ram_wdata, ram_we, tx_valid, tx_data, busy, done, seq_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h we=%b txv=%b txd=%h busy=%b done=%b err=%b, required all 0",
               ram_addr, ram_wdata, ram_we, tx_valid, tx_data, busy, done, seq_err);
    end
    rst = 1'b0;
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_quant;
    logic [23:0] d [0:3];
    d[0] = 24'h001234; d[1] = 24'h7FFF00; d[2] = 24'hFFFF00; d[3] = 24'h800000;
    for (int f = 0; f < 4; f++) begin
      tx_ready = 1'b1;
      kick;
      for (int i = 0; i < 4; i++) put(i, f == 0 ? d[i] : 24'($urandom), 1'b1);
      finish_frame($sformatf("quant_f%0d", f), 1'b0);
      checks++;
      if (seq_err !== 1'b0) begin
        errors++;
        $display("FAIL quant_f%0d seq_err: got %b, required 0", f, seq_err);
      end
    end
  endtask

  task automatic test_write_timing;
    tx_ready = 1'b0;
    kick;
    for (int i = 0; i < 4; i++) begin
      put(i, 24'($urandom), 1'b1);
      in_valid = 1'b0;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 13'(i) || ram_wdata !== exp_mem[i]) begin
        errors++;
        $display("FAIL wr_timing%0d: got we=%b addr=%0d wdata=%h, required we=1 addr=%0d wdata=%h",
                 i, ram_we, ram_addr, ram_wdata, i, exp_mem[i]);
      end
    end
    step;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 13'd0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr_cycle: got we=%b addr=%0d txv=%b, required we=0 addr=0 txv=0", ram_we, ram_addr, tx_valid);
    end
    step;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait_cycle: got txv=%b, required 0", tx_valid);
    end
    step;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_mem[0]) begin
      errors++;
      $display("FAIL send_cycle: got txv=%b txd=%h, required txv=1 txd=%h", tx_valid, tx_data, exp_mem[0]);
    end
    tx_ready = 1'b1;
    finish_frame("write_timing", 1'b0);
  endtask

  task automatic test_backpressure;
    logic [7:0] held;
    int n;
    tx_ready = 1'b0;
    kick;
    for (int i = 0; i < 4; i++) put(i, 24'($urandom), 1'b1);
    n = 0;
    while (!tx_valid && n < 20) begin
      step;
      n++;
    end
    held = tx_data;
    checks++;
    if (tx_valid !== 1'b1 || held !== exp_mem[0]) begin
      errors++;
      $display("FAIL bp_first: got txv=%b txd=%h, required txv=1 txd=%h", tx_valid, held, exp_mem[0]);
    end
    for (int c = 0; c < 20; c++) begin
      step;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: got txv=%b txd=%h, required txv=1 txd=%h", c, tx_valid, tx_data, held);
      end
    end
    finish_frame("backpressure", 1'b1);
  endtask

  task automatic test_seq_err;
    int base;
    tx_ready = 1'b1;
    kick;
    put(0, 24'($urandom), 1'b1);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_first: got %b, required 0", seq_err);
    end
    put(2, 24'($urandom), 1'b1);
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_second: got %b, required 1", seq_err);
    end
    put(1, 24'($urandom), 1'b1);
    put(3, 24'($urandom), 1'b1);
    finish_frame("seq_skip", 1'b0);
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_sticky: got %b, required 1", seq_err);
    end
    kick;
    base = wr_seen;
    for (int i = 0; i < 4; i++) put(i, 24'($urandom), 1'b1);
    put(0, 24'($urandom), 1'b0);
    checks++;
    if (ram_we !== 1'b0 || seq_err !== 1'b1 || wr_seen - base != 4) begin
      errors++;
      $display("FAIL seq_fifth: got we=%b err=%b writes=%0d, required we=0 err=1 writes=4", ram_we, seq_err, wr_seen - base);
    end
    finish_frame("seq_fifth", 1'b0);
    kick;
    put(0, 24'($urandom), 1'b1);
    put(1, 24'($urandom), 1'b1);
    in_done = 1'b1;
    step;
    in_done = 1'b0;
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_early_done: got %b, required 1", seq_err);
    end
    finish_frame("seq_early_done", 1'b0);
  endtask

  task automatic test_reset_start;
    int n;
    tx_ready = 1'b0;
    kick;
    put(0, 24'($urandom), 1'b1);
    put(0, 24'($urandom), 1'b1);
    put(2, 24'($urandom), 1'b1);
    put(3, 24'($urandom), 1'b1);
    n = 0;
    while (!tx_valid && n < 20) begin
      step;
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1 || seq_err !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got txv=%b err=%b, required txv=1 err=1", tx_valid, seq_err);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || seq_err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got txv=%b busy=%b err=%b done=%b, required all 0", tx_valid, busy, seq_err, done);
    end
    tx_ready = 1'b1;
    kick;
    put(0, 24'($urandom), 1'b1);
    put(1, 24'($urandom), 1'b1);
    kick;
    put(2, 24'($urandom), 1'b1);
    put(3, 24'($urandom), 1'b1);
    checks++;
    if (seq_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got err=%b busy=%b, required err=0 busy=1", seq_err, busy);
    end
    finish_frame("start_ignored", 1'b0);
  endtask

  initial begin
    test_reset;
    test_quant;
    test_write_timing;
    test_backpressure;
    test_seq_err;
    test_reset_start;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
